// File: rtl/ram_reg_pkg.sv
// Shared constants for the registered-address RAM: default geometry and derived depth.
package ram_reg_pkg;

    localparam int RAM_DATA_WIDTH = 8;
    localparam int RAM_ADDR_WIDTH = 11;
    localparam int RAM_DEPTH      = 1 << RAM_ADDR_WIDTH;

endpackage : ram_reg_pkg

// File: rtl/ram_reg_if.sv
// Bus bundle between a RAM user (master) and the registered-address RAM (slave).
interface ram_reg_if
    import ram_reg_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) ();

    logic                  we;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ADDR_WIDTH-1:0] addr_out;

    modport master (
        output we,
        output data_in,
        output addr_in,
        input  data_out,
        input  addr_out
    );

    modport slave (
        input  we,
        input  data_in,
        input  addr_in,
        output data_out,
        output addr_out
    );

endinterface : ram_reg_if

// File: rtl/ram_reg_mem.sv
// Storage array: synchronous write port, asynchronous read port, no reset on contents.
module ram_reg_mem
    import ram_reg_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Contents survive reset and are undefined until written.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port: one word per enabled rising edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port is combinational from the (already registered) read address,
    // so a write to that address shows up right after the edge that commits it.
    assign rdata_o = mem_q[raddr_i];

endmodule : ram_reg_mem

// File: rtl/ram_reg.sv
// Single-port RAM with a registered address: addr_in is captured every edge and
// the array is read at the captured address, giving one clock of read latency.
module ram_reg
    import ram_reg_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    ram_reg_if.slave  bus
);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  we_gated;
    logic [DATA_WIDTH-1:0] rd_data;

    // Address register always follows addr_in, independent of we.
    always_comb begin
        addr_d = bus.addr_in;
    end

    // Address register: cleared immediately when reset asserts, so the read
    // port falls back to word 0 without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Writes are blocked for as long as reset is held; the array itself is never cleared.
    assign we_gated = bus.we & rst_n;

    ram_reg_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (we_gated),
        .waddr_i (bus.addr_in),
        .wdata_i (bus.data_in),
        .raddr_i (addr_q),
        .rdata_o (rd_data)
    );

    // Outputs come only from the address register and the array, never from the inputs directly.
    assign bus.data_out = rd_data;
    assign bus.addr_out = addr_q;

endmodule : ram_reg

// File: tb/tb_ram_reg.sv
// Scoreboard bench for ram_reg: directed vectors push their hand-computed
// expectations; a monitor pops and compares one clock later.
module tb_ram_reg;

    localparam int DW = 8;
    localparam int AW = 11;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;
    exp_t exp_q[$];

    ram_reg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_reg #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 20 ns clock, first rising edge at 10 ns.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one clock's worth of inputs and queue the value expected after the edge.
    task automatic cycle(input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_d);
        exp_t e;
        @(negedge clk);
        bus.we      = w;
        bus.addr_in = a;
        bus.data_in = d;
        e.addr = a;
        e.data = exp_d;
        exp_q.push_back(e);
    endtask

    // Monitor: just after each rising edge, compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("addr_out", 32'(bus.addr_out), 32'(e.addr));
                check("data_out", 32'(bus.data_out), 32'(e.data));
                $display("vec addr_in=%h -> addr_out=%h data_out=%h (exp %h/%h)",
                         e.addr, bus.addr_out, bus.data_out, e.addr, e.data);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n       = 1'b1;
        bus.we      = 1'b0;
        bus.addr_in = '0;
        bus.data_in = '0;

        // Asynchronous clear before any clock edge has occurred.
        #5 rst_n = 1'b0;
        #1 check("reset_async_addr", 32'(bus.addr_out), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 check("reset_held_addr", 32'(bus.addr_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write i to address i, then read them back.
        for (int i = 0; i <= 10; i++) cycle(1'b1, AW'(i), DW'(i), DW'(i));
        for (int i = 0; i <= 10; i++) cycle(1'b0, AW'(i), 8'h00, DW'(i));

        // Top of the address range.
        cycle(1'b1, 11'h7FF, 8'hA5, 8'hA5);
        cycle(1'b0, 11'h7FF, 8'h00, 8'hA5);
        cycle(1'b0, 11'h00A, 8'h00, 8'h0A);
        cycle(1'b0, 11'h7FF, 8'h00, 8'hA5);

        // Back-to-back writes to a held address: new data each cycle.
        cycle(1'b1, 11'd5, 8'h11, 8'h11);
        cycle(1'b1, 11'd5, 8'h22, 8'h22);
        cycle(1'b0, 11'd5, 8'h00, 8'h22);

        // Registered address already 6, then a write to 6 must show next edge.
        cycle(1'b0, 11'd6, 8'h00, 8'h06);
        cycle(1'b1, 11'd6, 8'h66, 8'h66);
        cycle(1'b0, 11'd6, 8'h00, 8'h66);

        // Retention across reset, and writes suppressed while reset is held.
        cycle(1'b1, 11'd3, 8'h3C, 8'h3C);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_addr", 32'(bus.addr_out), 32'h0);
        check("midreset_data", 32'(bus.data_out), 32'h00);
        bus.we      = 1'b1;
        bus.addr_in = 11'd4;
        bus.data_in = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        #1 check("reset_we_addr", 32'(bus.addr_out), 32'h0);
        @(negedge clk);
        bus.we = 1'b0;
        rst_n  = 1'b1;
        cycle(1'b0, 11'd3, 8'h00, 8'h3C);
        cycle(1'b0, 11'd4, 8'h00, 8'h04);
        cycle(1'b0, 11'd0, 8'h00, 8'h00);

        // Let the monitor consume everything that was queued.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_ram_reg

// File: doc/ram_reg.md
RAM_REG -- requirements
Module: ram_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 11, SHALL set the address width; depth SHALL be 2**ADDR_WIDTH words (2048 by default).
REQ-003 clk  input  1  SHALL be the single clock; all sequential logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 we  input  1  SHALL be the write enable, active-high, sampled on the rising clk edge.
REQ-006 data_in  input  DATA_WIDTH  SHALL be the write data.
REQ-007 addr_in  input  ADDR_WIDTH  SHALL be the write address and the read address (sampled into the address register).
REQ-008 data_out  output  DATA_WIDTH  SHALL be the read data at the registered address.
REQ-009 addr_out  output  ADDR_WIDTH  SHALL be the registered address.

Function
REQ-010 Each rising clk edge with rst_n high and we=1 SHALL write data_in into mem[addr_in].
REQ-011 Each rising clk edge with rst_n high SHALL load addr_in into the address register, regardless of we.
REQ-012 addr_out SHALL equal the address register at all times.
REQ-013 data_out SHALL be mem[address register], read combinationally from the array; effective read latency is one clock from addr_in.
REQ-014 Read-during-write to the same address SHALL return the newly written data in the following cycle (new-data behaviour); no stale-data bypass path is needed.
REQ-015 With we=0 the array SHALL be unchanged; data_out SHALL track any later write to the registered address on the next edge.
REQ-016 The full address range 0..2**ADDR_WIDTH-1 SHALL be valid; there SHALL be no wrap-around or out-of-range handling beyond natural ADDR_WIDTH truncation.
REQ-017 data_in and addr_in SHALL never be used combinationally to drive an output.

Reset
REQ-018 Assertion of rst_n=0 SHALL clear the address register to 0 immediately, so addr_out=0 and data_out=mem[0].
REQ-019 Reset SHALL NOT clear or modify array contents; contents SHALL be retained across reset, and are undefined at power-up until written.
REQ-020 While rst_n=0, writes SHALL be suppressed.
REQ-021 After rst_n deasserts, the first rising edge SHALL resume normal operation; deassertion mid-operation SHALL need no extra recovery cycles.

Structure
REQ-022 Shared package ram_reg_pkg SHALL hold the DATA_WIDTH and ADDR_WIDTH defaults and a derived DEPTH constant.
REQ-023 Sub-module ram_reg_mem SHALL contain the storage array with a synchronous write port and an asynchronous read port.
REQ-024 Top-level ram_reg SHALL contain the address register and the reset logic, and SHALL instantiate ram_reg_mem.
REQ-025 The array SHALL be coded to infer block or distributed RAM, with no reset on the array.

Verification
REQ-026 Scenario: rst_n=0 pulse -> addr_out=0 immediately, asynchronously, without waiting for a clock edge.
REQ-027 Scenario: we=1, write data 0x00..0x0A to addresses 0..10, one per 20 ns clock; then we=0, read addresses 0..10 -> data_out=addr value one cycle after each addr_in, and addr_out lags addr_in by one cycle.
REQ-028 Scenario: write 0xA5 to address 0x7FF, then read it -> data_out=0xA5 and addr_out=0x7FF.
REQ-029 Scenario: hold addr_in=5 with we=1, data 0x11 then 0x22 on consecutive edges -> data_out=0x11 then 0x22, one cycle after each write.
REQ-030 Scenario: write address 3=0x3C, assert then release rst_n, read address 3 -> 0x3C, proving contents are retained.
REQ-031 Scenario: we=1 held while rst_n=0 across edges with addr_in=4 and data_in=0xFF -> mem[4] unchanged after reset.
